cook_timer_control: RTL and testbench

Sequencing controller for the countdown timer datapath. It owns the BCD `counter_mod10` chain (seconds and minutes digits) and drives the chain's `loadn`, `clearn` and `en` inputs. It generates the per-tick count enable from a prescaler, runs the start/pause/stop/done state machine from user buttons and the door switch, and drives the cooking and alarm indicators.

---
 rtl/cook_timer_if.sv | 33 +++
 rtl/cook_timer_control.sv | 129 ++++++++++++
 tb/tb_cook_timer_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cook_timer_if.sv
// ============================================================================
// Module      : cook_timer_if
// Description : Control/status bundle between the cook timer sequencer and
//               its surroundings (buttons, door switch, BCD counter chain).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cook_timer_if;
    logic       load_req;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_zero;
    logic       loadn;
    logic       cnt_clearn;
    logic       en;
    logic       mag_on;
    logic       done;
    logic [1:0] state;

    modport master (
        output load_req, startn, stopn, door_closed, timer_zero,
        input  loadn, cnt_clearn, en, mag_on, done, state
    );

    modport slave (
        input  load_req, startn, stopn, door_closed, timer_zero,
        output loadn, cnt_clearn, en, mag_on, done, state
    );
endinterface

`default_nettype wire

// File: rtl/cook_timer_control.sv
// ============================================================================
// Module      : cook_timer_control
// Description : Start/pause/stop/done sequencer for the countdown timer; owns
//               the tick prescaler and the counter chain load/clear/enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cook_timer_control #(
    parameter int TICK_DIV  = 10,
    parameter int DONE_HOLD = 20
) (
    input  wire logic    clock,
    input  wire logic    clearn,
    cook_timer_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_COOK  = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int c_PRESC_W = $clog2(TICK_DIV);
    localparam int c_HOLD_W  = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_MAX  = c_HOLD_W'(DONE_HOLD - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_HOLD_W-1:0]  r_hold;
    logic                 r_startn_q;
    logic                 r_stopn_q;
    logic                 r_loadn;
    logic                 r_cnt_clearn;

    logic                 w_start_ev;
    logic                 w_stop_ev;
    logic                 w_mag_on;
    logic                 w_done;
    logic                 w_en;
    logic                 w_load_req;
    logic                 w_clr_req;

    assign w_start_ev = ~bus.startn & r_startn_q;
    assign w_stop_ev  = ~bus.stopn  & r_stopn_q;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A stop in the same cycle as a start keeps the block idle.
                if (!w_stop_ev && w_start_ev && bus.door_closed && !bus.timer_zero)
                    w_state_nxt = c_ST_COOK;
            end
            c_ST_COOK: begin
                if (bus.timer_zero)
                    w_state_nxt = c_ST_DONE;
                else if (!bus.door_closed || w_stop_ev)
                    w_state_nxt = c_ST_PAUSE;
            end
            c_ST_PAUSE: begin
                if (w_stop_ev)
                    w_state_nxt = c_ST_IDLE;
                else if (w_start_ev && bus.door_closed)
                    w_state_nxt = c_ST_COOK;
            end
            c_ST_DONE: begin
                if (w_stop_ev || (r_hold == c_HOLD_MAX))
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_mag_on   = (r_state == c_ST_COOK);
        w_done     = (r_state == c_ST_DONE);
        // Masked at zero so the counter chain never underflows to 9.
        w_en       = w_mag_on && (r_presc == c_PRESC_MAX) && !bus.timer_zero;
        w_clr_req  = w_stop_ev && ((r_state == c_ST_IDLE) || (r_state == c_ST_PAUSE));
        // Gating on r_loadn keeps a held load_req from stretching the pulse.
        w_load_req = bus.load_req && (r_state == c_ST_IDLE) && r_loadn && !w_clr_req;
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_presc      <= '0;
            r_hold       <= '0;
            r_startn_q   <= 1'b1;
            r_stopn_q    <= 1'b1;
            r_loadn      <= 1'b1;
            r_cnt_clearn <= 1'b1;
        end else begin
            r_startn_q   <= bus.startn;
            r_stopn_q    <= bus.stopn;
            r_loadn      <= ~w_load_req;
            r_cnt_clearn <= ~w_clr_req;

            if ((r_state == c_ST_IDLE) && (w_state_nxt == c_ST_COOK))
                r_presc <= '0;
            else if (r_state == c_ST_COOK)
                r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;

            if ((r_state == c_ST_DONE) && (w_state_nxt == c_ST_DONE))
                r_hold <= r_hold + 1'b1;
            else
                r_hold <= '0;
        end
    end

    assign bus.state      = r_state;
    assign bus.mag_on     = w_mag_on;
    assign bus.done       = w_done;
    assign bus.en         = w_en;
    assign bus.loadn      = r_loadn;
    assign bus.cnt_clearn = r_cnt_clearn;

endmodule

`default_nettype wire

// File: tb/tb_cook_timer_control.sv
// ============================================================================
// Module      : tb_cook_timer_control
// Description : Directed and random stimulus for cook_timer_control, checked
//               cycle by cycle against a behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cook_timer_control;

    localparam int TICK_DIV  = 10;
    localparam int DONE_HOLD = 20;

    logic clock  = 1'b0;
    logic clearn = 1'b1;

    always #5 clock = ~clock;

    cook_timer_if bus ();

    cook_timer_control #(
        .TICK_DIV  (TICK_DIV),
        .DONE_HOLD (DONE_HOLD)
    ) dut (
        .clock  (clock),
        .clearn (clearn),
        .bus    (bus)
    );

    int checks = 0;
    int passed = 0;

    // Model: mode 0 idle, 1 cooking, 2 paused, 3 alarm; phase counts cooking
    // cycles modulo TICK_DIV; env_count is the remaining time in the chain.
    int m_mode;
    int m_phase;
    int m_done_left;
    bit m_loadn;
    bit m_clr;
    bit m_prev_start;
    bit m_prev_stop;
    int env_count = 0;
    int load_val  = 0;
    int n_en      = 0;
    int n_done    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_phase      = 0;
        m_done_left  = 0;
        m_loadn      = 1'b1;
        m_clr        = 1'b1;
        m_prev_start = 1'b1;
        m_prev_stop  = 1'b1;
    endtask

    function automatic bit exp_en();
        return (m_mode == 1) && (m_phase == TICK_DIV - 1) && (env_count != 0);
    endfunction

    task automatic tick();
        bit en_e, sev, tev, tz, wl, wc;
        @(negedge clock);
        en_e = exp_en();
        check("state",      32'(bus.state),      32'(m_mode));
        check("mag_on",     32'(bus.mag_on),     32'(m_mode == 1));
        check("done",       32'(bus.done),       32'(m_mode == 3));
        check("en",         32'(bus.en),         32'(en_e));
        check("loadn",      32'(bus.loadn),      32'(m_loadn));
        check("cnt_clearn", 32'(bus.cnt_clearn), 32'(m_clr));
        if (bus.en)   n_en++;
        if (bus.done) n_done++;
        @(posedge clock);
        #1;
        tz  = (env_count == 0);
        sev = !bus.startn && m_prev_start;
        tev = !bus.stopn && m_prev_stop;
        wc  = tev && (m_mode == 0 || m_mode == 2);
        wl  = bus.load_req && (m_mode == 0) && m_loadn && !wc;
        if (!m_clr)        env_count = 0;
        else if (!m_loadn) env_count = load_val;
        else if (en_e)     env_count = env_count - 1;
        case (m_mode)
            0: if (!tev && sev && bus.door_closed && !tz) begin
                   m_mode  = 1;
                   m_phase = 0;
               end
            1: begin
                   m_phase = (m_phase + 1) % TICK_DIV;
                   if (tz) begin
                       m_mode      = 3;
                       m_done_left = DONE_HOLD;
                   end else if (!bus.door_closed || tev) begin
                       m_mode = 2;
                   end
               end
            2: if (tev) m_mode = 0;
               else if (sev && bus.door_closed) m_mode = 1;
            default: begin
                   m_done_left = m_done_left - 1;
                   if (tev || m_done_left == 0) m_mode = 0;
               end
        endcase
        m_loadn        = !wl;
        m_clr          = !wc;
        m_prev_start   = bus.startn;
        m_prev_stop    = bus.stopn;
        bus.timer_zero = (env_count == 0);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press_start();
        bus.startn = 1'b0;
        tick();
        bus.startn = 1'b1;
    endtask

    task automatic press_stop();
        bus.stopn = 1'b0;
        tick();
        bus.stopn = 1'b1;
    endtask

    task automatic load(input int v);
        load_val     = v;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        run(2);
    endtask

    initial begin
        bus.load_req    = 1'b0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.door_closed = 1'b1;
        bus.timer_zero  = 1'b1;
        model_reset();

        #1 clearn = 1'b0;
        #2;
        check("rst_state",      32'(bus.state),      32'd0);
        check("rst_loadn",      32'(bus.loadn),      32'd1);
        check("rst_cnt_clearn", 32'(bus.cnt_clearn), 32'd1);
        check("rst_en",         32'(bus.en),         32'd0);
        check("rst_mag_on",     32'(bus.mag_on),     32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        @(posedge clock);
        #1 clearn = 1'b1;
        run(2);

        // Load 3, cook to zero, alarm, back to idle; load_req mid-cook ignored.
        load(3);
        n_en   = 0;
        n_done = 0;
        press_start();
        run(5);
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        run(54);
        check("cook3_en_count",  32'(n_en),   32'd3);
        check("cook3_done_len",  32'(n_done), 32'(DONE_HOLD));
        check("cook3_end_state", 32'(bus.state), 32'd0);

        // Door opens at prescaler 6, then resume: tick in 3rd cooking cycle.
        load(5);
        press_start();
        run(6);
        bus.door_closed = 1'b0;
        tick();
        run(3);
        check("pause_state", 32'(bus.state), 32'd2);
        press_start();
        run(2);
        bus.door_closed = 1'b1;
        run(2);
        press_start();
        n_en = 0;
        run(2);
        check("resume_no_early_en", 32'(n_en), 32'd0);
        tick();
        check("resume_en_3rd", 32'(n_en), 32'd1);

        // Stop -> pause, stop -> idle with clear, stop in idle -> clear.
        run(3);
        press_stop();
        run(2);
        press_stop();
        run(3);
        check("stop_idle_state", 32'(bus.state), 32'd0);
        press_stop();
        run(3);

        // Ignored starts: timer at zero, door open, held button.
        press_start();
        run(3);
        load(4);
        bus.door_closed = 1'b0;
        press_start();
        run(3);
        bus.startn = 1'b0;
        run(50);
        bus.door_closed = 1'b1;
        run(5);
        check("held_start_idle", 32'(bus.state), 32'd0);
        bus.startn = 1'b1;
        run(2);

        // Asynchronous reset in a cycle where a tick is being issued.
        press_start();
        run(19);
        #2;
        check("pre_rst_en", 32'(bus.en), 32'd1);
        clearn = 1'b0;
        #1;
        check("arst_state",  32'(bus.state),  32'd0);
        check("arst_mag_on", 32'(bus.mag_on), 32'd0);
        check("arst_en",     32'(bus.en),     32'd0);
        model_reset();
        @(posedge clock);
        #1 clearn = 1'b1;
        press_start();
        n_en = 0;
        run(9);
        check("post_rst_no_en", 32'(n_en), 32'd0);
        tick();
        check("post_rst_en_10", 32'(n_en), 32'd1);
        press_stop();
        run(1);
        press_stop();
        run(2);

        // Random buttons, door and keypad loads.
        for (int i = 0; i < 1500; i++) begin
            bus.startn = ($urandom_range(0, 7) != 0);
            bus.stopn  = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 19) == 0) bus.door_closed = ~bus.door_closed;
            bus.load_req = ($urandom_range(0, 15) == 0);
            if (bus.load_req) load_val = $urandom_range(0, 9);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
